// File: rtl/fc_param_layer.sv
// Fully connected layer y = act(W * x) with a resident weight memory.
// x is streamed in one element at a time, then each group of P output
// neurons is computed column by column, one column per cycle, through a
// two-register pipeline (weight/x read, saturated product) into P
// saturating accumulators, and the group's results are streamed out.
//
// Handshake rule for every stream in this block: a word moves only on a
// rising clock edge where valid and ready are both 1; the producer holds
// valid and data stable until that edge, and ready never depends on valid.
module fc_param_layer #(
    parameter int M    = 8,
    parameter int N    = 8,
    parameter int T    = 12,
    parameter int P    = 2,
    parameter int RELU = 1,
    localparam int AW  = (M * N > 1) ? $clog2(M * N) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                input_valid,
    output logic                input_ready,
    input  logic signed [T-1:0] input_data,
    output logic                output_valid,
    input  logic                output_ready,
    output logic signed [T-1:0] output_data,
    input  logic                w_wr_en,
    input  logic [AW-1:0]       w_addr,
    input  logic signed [T-1:0] w_data,
    output logic                w_ready,
    output logic [2:0]          o_dbg_state
);

    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int G  = M / P;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam int LW = (P > 1) ? $clog2(P) : 1;

    localparam logic [KW-1:0] K_LAST = KW'(N - 1);
    localparam logic [GW-1:0] G_LAST = GW'(G - 1);
    localparam logic [LW-1:0] L_LAST = LW'(P - 1);

    localparam logic signed [T-1:0] SAT_MAX = {1'b0, {(T-1){1'b1}}};
    localparam logic signed [T-1:0] SAT_MIN = {1'b1, {(T-1){1'b0}}};

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD_X  = 3'd1;
    localparam logic [2:0] S_COMPUTE = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_OUTPUT  = 3'd4;

    logic [2:0]          r_state;
    logic [KW-1:0]       r_k;        // x load index, then column index
    logic [GW-1:0]       r_group;
    logic [LW-1:0]       r_lane;
    logic                r_drain;    // second drain cycle
    logic                r_rd_valid;
    logic                r_prod_valid;

    logic signed [T-1:0] r_w_mem [0:M*N-1];
    logic signed [T-1:0] r_x     [0:N-1];
    logic signed [T-1:0] r_rd_w  [0:P-1];
    logic signed [T-1:0] r_rd_x;
    logic signed [T-1:0] r_prod  [0:P-1];
    logic signed [T-1:0] r_acc   [0:P-1];

    logic                w_in_fire;
    logic                w_out_fire;
    logic                w_wr_fire;
    logic                w_acc_clr;
    logic [KW-1:0]       w_x_idx;
    logic [AW-1:0]       w_rd_addr [0:P-1];
    logic signed [T-1:0] w_rd_w    [0:P-1];
    logic signed [T-1:0] w_y;

    // Full-precision product clamped to the T-bit signed range.
    function automatic logic signed [T-1:0] sat_mul(input logic signed [T-1:0] a,
                                                    input logic signed [T-1:0] b);
        logic signed [2*T-1:0] full;
        full = (2*T)'(a) * (2*T)'(b);
        if (full[2*T-1:T-1] == {(T+1){full[2*T-1]}})
            return full[T-1:0];
        else
            return full[2*T-1] ? SAT_MIN : SAT_MAX;
    endfunction

    // T-bit add that clamps instead of wrapping on same-sign overflow.
    function automatic logic signed [T-1:0] sat_add(input logic signed [T-1:0] a,
                                                    input logic signed [T-1:0] b);
        logic signed [T-1:0] sum;
        sum = a + b;
        if ((a[T-1] == b[T-1]) && (sum[T-1] != a[T-1]))
            return a[T-1] ? SAT_MIN : SAT_MAX;
        else
            return sum;
    endfunction

    // Ready outputs are forced low while reset is held.
    assign input_ready  = reset_n && ((r_state == S_IDLE) || (r_state == S_LOAD_X));
    assign w_ready      = reset_n && (r_state == S_IDLE);
    assign output_valid = (r_state == S_OUTPUT);
    assign o_dbg_state  = r_state;

    assign w_in_fire  = input_valid && input_ready;
    assign w_out_fire = output_valid && output_ready;
    // Out-of-range addresses (M*N not a power of two) are dropped.
    assign w_wr_fire  = w_wr_en && w_ready && (int'(w_addr) < M * N);
    assign w_x_idx    = (r_state == S_IDLE) ? '0 : r_k;

    // Accumulators restart when a vector arrives and when moving to the next group.
    assign w_acc_clr = ((r_state == S_IDLE) && w_in_fire) ||
                       ((r_state == S_OUTPUT) && w_out_fire &&
                        (r_lane == L_LAST) && (r_group != G_LAST));

    assign w_y         = ((RELU != 0) && r_acc[r_lane][T-1]) ? '0 : r_acc[r_lane];
    assign output_data = (r_state == S_OUTPUT) ? w_y : '0;

    // Weight fetch for column r_k of every lane in the current group.
    always_comb begin
        for (int p = 0; p < P; p++) begin
            w_rd_addr[p] = AW'((int'(r_group) * P + p) * N + int'(r_k));
            w_rd_w[p]    = r_w_mem[w_rd_addr[p]];
        end
    end

    // Weight memory: written only while idle, deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr_fire)
            r_w_mem[w_addr] <= w_data;
    end

    // Input vector buffer: filled from the x stream, contents not reset.
    always_ff @(posedge clk) begin
        if (w_in_fire)
            r_x[w_x_idx] <= input_data;
    end

    // Control FSM: load x, compute each group, drain pipeline, stream group out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_group <= '0;
            r_lane  <= '0;
            r_drain <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_in_fire) begin
                        r_group <= '0;
                        if (N == 1) begin
                            r_k     <= '0;
                            r_state <= S_COMPUTE;
                        end else begin
                            r_k     <= KW'(1);
                            r_state <= S_LOAD_X;
                        end
                    end
                end
                S_LOAD_X: begin
                    if (w_in_fire) begin
                        if (r_k == K_LAST) begin
                            r_k     <= '0;
                            r_state <= S_COMPUTE;
                        end else begin
                            r_k <= r_k + KW'(1);
                        end
                    end
                end
                S_COMPUTE: begin
                    if (r_k == K_LAST) begin
                        r_k     <= '0;
                        r_drain <= 1'b0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                S_DRAIN: begin
                    r_drain <= 1'b1;
                    if (r_drain) begin
                        r_lane  <= '0;
                        r_state <= S_OUTPUT;
                    end
                end
                S_OUTPUT: begin
                    if (w_out_fire) begin
                        if (r_lane == L_LAST) begin
                            r_lane <= '0;
                            if (r_group == G_LAST) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_group <= r_group + GW'(1);
                                r_state <= S_COMPUTE;
                            end
                        end else begin
                            r_lane <= r_lane + LW'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // MAC pipeline: read registers, saturated product, saturating accumulate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_valid   <= 1'b0;
            r_prod_valid <= 1'b0;
            r_rd_x       <= '0;
            for (int p = 0; p < P; p++) begin
                r_rd_w[p] <= '0;
                r_prod[p] <= '0;
                r_acc[p]  <= '0;
            end
        end else begin
            r_rd_valid   <= (r_state == S_COMPUTE);
            r_prod_valid <= r_rd_valid;
            if (r_state == S_COMPUTE)
                r_rd_x <= r_x[r_k];
            for (int p = 0; p < P; p++) begin
                if (r_state == S_COMPUTE)
                    r_rd_w[p] <= w_rd_w[p];
                if (r_rd_valid)
                    r_prod[p] <= sat_mul(r_rd_w[p], r_rd_x);
                if (w_acc_clr)
                    r_acc[p] <= '0;
                else if (r_prod_valid)
                    r_acc[p] <= sat_add(r_acc[p], r_prod[p]);
            end
        end
    end

endmodule

// File: tb/tb_fc_param_layer.sv
// Bench for fc_param_layer: two instances (RELU=0 and RELU=1) share every
// input, so each vector checks the linear and rectified results together.
module tb_fc_param_layer;

    localparam int M  = 4;
    localparam int N  = 4;
    localparam int T  = 12;
    localparam int P  = 2;
    localparam int AW = 4;

    typedef struct {
        logic [M*N-1:0][T-1:0] w;
        logic [N-1:0][T-1:0]   x;
        logic [M-1:0][T-1:0]   y_lin;
        logic [M-1:0][T-1:0]   y_relu;
        bit                    rnd;
    } vec_t;

    vec_t vecs [6];

    logic                clk = 1'b0;
    logic                reset_n;
    logic                input_valid;
    logic signed [T-1:0] input_data;
    logic                output_ready;
    logic                w_wr_en;
    logic [AW-1:0]       w_addr;
    logic signed [T-1:0] w_data;

    logic                in_rdy_l, out_v_l, w_rdy_l;
    logic signed [T-1:0] out_d_l;
    logic [2:0]          st_l;
    logic                in_rdy_r, out_v_r, w_rdy_r;
    logic signed [T-1:0] out_d_r;
    logic [2:0]          st_r;

    logic [T-1:0] exp_q[$];
    logic [T-1:0] exp_r_q[$];

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  rnd_ready = 1'b0;
    bit  hold = 1'b0;
    logic signed [T-1:0] held_l, held_r;

    // Clock and DUTs
    always #5 clk = ~clk;

    fc_param_layer #(.M(M), .N(N), .T(T), .P(P), .RELU(0)) dut_lin (
        .clk(clk), .reset_n(reset_n),
        .input_valid(input_valid), .input_ready(in_rdy_l), .input_data(input_data),
        .output_valid(out_v_l), .output_ready(output_ready), .output_data(out_d_l),
        .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data), .w_ready(w_rdy_l),
        .o_dbg_state(st_l)
    );

    fc_param_layer #(.M(M), .N(N), .T(T), .P(P), .RELU(1)) dut_relu (
        .clk(clk), .reset_n(reset_n),
        .input_valid(input_valid), .input_ready(in_rdy_r), .input_data(input_data),
        .output_valid(out_v_r), .output_ready(output_ready), .output_data(out_d_r),
        .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data), .w_ready(w_rdy_r),
        .o_dbg_state(st_r)
    );

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Driver: weight write, waits for w_ready first
    task automatic write_w(input int addr, input logic [T-1:0] data);
        int guard = 0;
        while (!w_rdy_l && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!w_rdy_l) check("w_ready_timeout", 0, 1);
        w_wr_en = 1'b1;
        w_addr  = AW'(addr);
        w_data  = data;
        @(posedge clk); #1;
        w_wr_en = 1'b0;
    endtask

    // Driver: stream one x vector, optional random idle gaps
    task automatic send_x(input logic [N-1:0][T-1:0] xv, input bit gaps);
        for (int i = 0; i < N; i++) begin
            int guard;
            bit accepted;
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
            input_valid = 1'b1;
            input_data  = xv[i];
            guard = 0;
            accepted = 1'b0;
            while (!accepted && guard < 400) begin
                @(negedge clk);
                accepted = in_rdy_l;
                @(posedge clk); #1;
                guard++;
            end
            if (!accepted) check("x_accept_timeout", 0, 1);
            input_valid = 1'b0;
        end
    endtask

    task automatic push_exp(input int v);
        for (int i = 0; i < M; i++) begin
            exp_q.push_back(vecs[v].y_lin[i]);
            exp_r_q.push_back(vecs[v].y_relu[i]);
        end
    endtask

    task automatic wait_done();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 3000) begin
            @(posedge clk); #1;
            guard++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    // Output ready: held high or 30% random duty
    initial begin
        output_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            output_ready = rnd_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    // Scoreboard: compares each accepted output, checks stability while stalled
    always @(negedge clk) begin
        logic [T-1:0] e, er;
        if (!reset_n) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("stall_valid", out_v_l, 1);
                check("stall_data", out_d_l, held_l);
                check("stall_data_relu", out_d_r, held_r);
            end
            if (out_v_l) begin
                check("w_ready_busy", w_rdy_l, 0);
                check("relu_valid", out_v_r, 1);
                if (output_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: got %0d expected none", out_d_l);
                    end else begin
                        e  = exp_q.pop_front();
                        er = exp_r_q.pop_front();
                        check("y", out_d_l, $signed(e));
                        check("y_relu", out_d_r, $signed(er));
                    end
                    hold = 1'b0;
                end else begin
                    hold   = 1'b1;
                    held_l = out_d_l;
                    held_r = out_d_r;
                end
            end else begin
                hold = 1'b0;
            end
        end
    end

    // Watchdog
    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    // Main sequence
    initial begin
        int cnt;
        int guard;
        reset_n     = 1'b0;
        input_valid = 1'b0;
        input_data  = '0;
        w_wr_en     = 1'b0;
        w_addr      = '0;
        w_data      = '0;

        for (int v = 0; v < 6; v++) begin
            vecs[v].w = '0;
            vecs[v].rnd = 1'b1;
        end
        // v0: identity, v1: -identity
        for (int r = 0; r < 4; r++) begin
            vecs[0].w[r*4+r] = 12'sd1;
            vecs[1].w[r*4+r] = -12'sd1;
        end
        vecs[0].rnd    = 1'b0;
        vecs[0].x      = {12'sd2, 12'sd7, -12'sd3, 12'sd5};
        vecs[0].y_lin  = {12'sd2, 12'sd7, -12'sd3, 12'sd5};
        vecs[0].y_relu = {12'sd2, 12'sd7, 12'sd0, 12'sd5};
        vecs[1].x      = {12'sd2, 12'sd7, -12'sd3, 12'sd5};
        vecs[1].y_lin  = {-12'sd2, -12'sd7, 12'sd3, -12'sd5};
        vecs[1].y_relu = {12'sd0, 12'sd0, 12'sd3, 12'sd0};
        // v2/v3: product and sum saturation at both rails
        for (int a = 0; a < 16; a++) begin
            vecs[2].w[a] = 12'sd2047;
            vecs[3].w[a] = 12'sd2047;
        end
        vecs[2].x      = {4{12'sd2047}};
        vecs[2].y_lin  = {4{12'sd2047}};
        vecs[2].y_relu = {4{12'sd2047}};
        vecs[3].rnd    = 1'b0;
        vecs[3].x      = {4{12'h800}};
        vecs[3].y_lin  = {4{12'h800}};
        vecs[3].y_relu = {4{12'sd0}};
        // v4: mixed-sign general matrix
        vecs[4].w = {12'sd2, 12'sd2, 12'sd2, 12'sd2,
                     12'sd10, 12'sd0, 12'sd0, 12'sd0,
                     12'sd0, 12'sd1, 12'sd0, -12'sd1,
                     12'sd4, 12'sd3, 12'sd2, 12'sd1};
        vecs[4].x      = {-12'sd5, 12'sd30, -12'sd20, 12'sd10};
        vecs[4].y_lin  = {12'sd30, -12'sd50, 12'sd20, 12'sd40};
        vecs[4].y_relu = {12'sd30, 12'sd0, 12'sd20, 12'sd40};
        // v5: accumulator clamps mid-sum, then recovers
        vecs[5].w = {12'sd0, 12'sd0, 12'sd0, 12'sd0,
                     12'sd0, 12'sd0, 12'sd1, 12'sd2047,
                     12'sd1000, -12'sd1000, -12'sd1000, -12'sd1000,
                     -12'sd1000, 12'sd1000, 12'sd1000, 12'sd1000};
        vecs[5].x      = {4{12'sd1}};
        vecs[5].y_lin  = {12'sd0, 12'sd2047, -12'sd1048, 12'sd1047};
        vecs[5].y_relu = {12'sd0, 12'sd2047, 12'sd0, 12'sd1047};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_input_ready", in_rdy_l, 0);
        check("rst_w_ready", w_rdy_l, 0);
        check("rst_output_valid", out_v_l, 0);
        check("rst_output_data", out_d_l, 0);
        check("rst_state", st_l, 0);
        check("rst_state_relu", st_r, 0);
        reset_n = 1'b1;
        #1;
        check("rel_input_ready", in_rdy_l, 1);
        check("rel_w_ready", w_rdy_l, 1);
        check("rel_w_ready_relu", w_rdy_r, 1);
        check("rel_input_ready_relu", in_rdy_r, 1);
        @(posedge clk); #1;

        // Table vectors, weights rewritten between back-to-back vectors
        for (int v = 0; v < 6; v++) begin
            rnd_ready = vecs[v].rnd;
            for (int a = 0; a < M*N; a++) write_w(a, vecs[v].w[a]);
            push_exp(v);
            send_x(vecs[v].x, vecs[v].rnd);
            if (v == 0) begin
                // Acceptance cycle is t; first output_valid expected in cycle t+N+3
                cnt = 0;
                while (!out_v_l && cnt < 50) begin
                    @(posedge clk); #1;
                    cnt++;
                end
                check("first_valid_cycle", cnt + 1, N + 3);
            end
            wait_done();
        end

        // Weight writes attempted while computing must be dropped
        rnd_ready = 1'b0;
        push_exp(5);
        send_x(vecs[5].x, 1'b0);
        check("state_compute", st_l, 2);
        check("w_ready_compute", w_rdy_l, 0);
        guard = 0;
        while (st_l != 3'd4 && guard < 50) begin
            w_wr_en = 1'b1;
            w_addr  = AW'(guard);
            w_data  = 12'h555;
            @(posedge clk); #1;
            guard++;
        end
        w_wr_en = 1'b0;
        wait_done();

        // Reset pulse during group 1 compute aborts the vector
        push_exp(5);
        send_x(vecs[5].x, 1'b0);
        guard = 0;
        while (exp_q.size() > 2 && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        check("abort_reach_group1", exp_q.size(), 2);
        guard = 0;
        while (st_l != 3'd2 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("abort_state_before", st_l, 2);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_output_valid", out_v_l, 0);
        check("abort_state", st_l, 0);
        check("abort_input_ready", in_rdy_l, 0);
        check("abort_output_data", out_d_l, 0);
        exp_q.delete();
        exp_r_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("no_stale_output", out_v_l, 0);
        check("idle_after_abort", st_l, 0);

        // Weights retained through reset
        push_exp(5);
        send_x(vecs[5].x, 1'b1);
        wait_done();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fc_param_layer.md
FC_PARAM_LAYER -- requirements
Module: fc_param_layer

Interface
REQ-001 SHALL have parameter M, default 8, meaning number of output neurons (rows of W).
REQ-002 SHALL have parameter N, default 8, meaning input vector length (columns of W).
REQ-003 SHALL have parameter T, default 12, meaning signed two's-complement data width.
REQ-004 SHALL have parameter P, default 2, meaning parallel MAC lanes; M divisible by P.
REQ-005 SHALL have parameter RELU, default 1, meaning apply ReLU to results when 1.
REQ-006 SHALL have clk  input  1  rising-edge clock, the only clock.
REQ-007 SHALL have reset_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have input_valid  input  1, input_ready  output  1, input_data  input  T  signed x element stream.
REQ-009 SHALL have output_valid  output  1, output_ready  input  1, output_data  output  T  signed y element stream.
REQ-010 SHALL have w_wr_en  input  1, w_addr  input  clog2(M*N), w_data  input  T signed, w_ready  output  1, weight write port; w_addr = row*N + col.

Function
REQ-011 SHALL transfer on a stream only in a cycle where valid and ready are both 1.
REQ-012 SHALL use states IDLE, LOAD_X, COMPUTE, DRAIN, OUTPUT.
REQ-013 IDLE: input_ready=1, w_ready=1; accepted x element goes to x[0], go LOAD_X (N=1: go COMPUTE).
REQ-014 SHALL write W[w_addr] only when w_wr_en=1 and w_ready=1; writes in other states ignored; w_ready=1 only in IDLE.
REQ-015 LOAD_X: input_ready=1; k-th accepted element stored at x[k]; after x[N-1] accepted, next cycle COMPUTE.
REQ-016 COMPUTE: one column per cycle for N cycles; lane p of group g accumulates W[g*P+p][k]*x[k].
REQ-017 Product: full 2T-bit, saturated to T bits (max 2^(T-1)-1, min -2^(T-1)), registered one cycle.
REQ-018 Accumulate: T-bit saturating add; on same-sign overflow clamp to max/min; accumulators cleared at start of each group.
REQ-019 DRAIN: exactly 2 cycles flushing read and product pipeline registers, then OUTPUT.
REQ-020 RELU=1: negative final sums output as 0; RELU=0: sums output unchanged.
REQ-021 OUTPUT: emits lanes p=0..P-1 of group g in order, output_valid=1 held with stable data until accepted.
REQ-022 After last lane of group g accepted: g<M/P-1 -> COMPUTE for g+1; else -> IDLE.
REQ-023 Latency: last x accepted at cycle t -> first output_valid at t+N+3 with output_ready held 1.
REQ-024 output_ready low stalls OUTPUT indefinitely without data loss; no input accepted outside IDLE/LOAD_X.
REQ-025 input_valid=0 mid-LOAD_X pauses loading; element count preserved.
REQ-026 Y order: y[0..M-1] ascending, exactly M outputs per input vector.

Reset
REQ-027 reset_n=0 SHALL asynchronously force IDLE, all counters and accumulators 0, output_valid=0, output_data=0.
REQ-028 input_ready and w_ready SHALL be 0 while reset_n=0 and 1 in first cycle after release.
REQ-029 Weight memory contents SHALL be retained across reset; x buffer contents undefined.
REQ-030 Reset asserted mid-LOAD_X/COMPUTE/OUTPUT SHALL abort the vector; no stale output after release.

Verification
REQ-031 M=4,N=4,T=12,P=2,RELU=0; W=identity, x=[5,-3,7,2], output_ready=1 -> y=[5,-3,7,2], first output_valid at t+7.
REQ-032 T=12, W all 2047, x all 2047 -> each product clamps 2047, every y=2047; W=2047, x=-2048 -> y=-2048.
REQ-033 RELU=1, W=-identity, x=[5,-3,7,2] -> y=[0,3,0,0].
REQ-034 output_ready random 30% duty, random input_valid gaps -> y matches golden model, data stable while stalled, w_ready=0 outside IDLE.
REQ-035 reset_n pulsed low during COMPUTE of group 1 -> output_valid=0 immediately, IDLE, weights intact; next vector correct.
REQ-036 Two back-to-back vectors with weight rewrite between -> second result uses new W; write attempts during COMPUTE ignored.
